// File: rtl/bus_memory.sv
// 64-bit RAM with independent instruction/data ports, latency counters,
// byte-lane writes and, with BUS_MEMORY_MMIO_EN, halt/console/int MMIO.
// Ports: phi2/rst clock and sync reset; instruction_* fetch port;
// data_* address/size; input_data* read port; output_data* write port;
// console_* FIFO drain; int_data/int_valid, halted, bus_error (sticky).
module bus_memory #(
   parameter int ADDR_BITS     = 12,
   parameter int READ_LATENCY  = 1,
   parameter int WRITE_LATENCY = 1,
   parameter int CONSOLE_DEPTH = 16
) (
   input  logic        phi2,
   input  logic        rst,
   input  logic [63:0] instruction_address,
   output logic [31:0] input_instruction,
   input  logic        input_instruction_request,
   output logic        input_instruction_valid,
   input  logic [63:0] data_address,
   input  logic [1:0]  data_size,
   output logic [63:0] input_data,
   input  logic        input_data_unsigned,
   input  logic        input_data_request,
   output logic        input_data_valid,
   input  logic [63:0] output_data,
   input  logic        output_data_request,
   output logic        output_data_complete,
   output logic [7:0]  console_data,
   output logic        console_valid,
   input  logic        console_ready,
   output logic [63:0] int_data,
   output logic        int_valid,
   output logic        halted,
   output logic        bus_error
);
   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [63:0] A_INT  = 64'hFFFF_FFFF_FFFF_FFF0;
   localparam logic [63:0] A_HALT = 64'hFFFF_FFFF_FFFF_FFF8;
   localparam logic [63:0] A_CON  = 64'hFFFF_FFFF_FFFF_FFFC;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

   logic [63:0] mem [DEPTH];

   state_e      i_state_q, i_state_d;
   logic [3:0]  i_cnt_q, i_cnt_d;
   logic [63:0] i_addr_q;
   logic [31:0] i_data_q;
   logic        i_mis, i_rng, i_mmio, i_err;
   logic [63:0] i_word;

   state_e      d_state_q, d_state_d;
   logic [3:0]  d_cnt_q, d_cnt_d;
   logic [63:0] d_addr_q, d_wdata_q, d_rdata_q;
   logic [1:0]  d_size_q;
   logic        d_uns_q, d_we_q, d_accept;
   logic        d_mis, d_rng, d_mmio, d_err, d_ram_ok, d_commit;
   logic        d_con, d_halt, d_int, d_hold, con_full;
   logic [63:0] d_word, d_sh, d_fmt, d_wsh;
   logic [7:0]  d_mask;
   logic        bus_error_q;

   // ---------------- instruction port ----------------
   always_comb begin
      i_state_d = i_state_q;
      i_cnt_d   = i_cnt_q;
      unique case (i_state_q)
         IDLE: if (input_instruction_request) begin
            i_state_d = WAIT;
            i_cnt_d   = 4'(READ_LATENCY - 1);
         end
         WAIT: if (i_cnt_q == 4'd0) i_state_d = DONE;
               else i_cnt_d = i_cnt_q - 4'd1;
         DONE: i_state_d = IDLE;
         default: i_state_d = IDLE;
      endcase
   end

   assign i_mis  = |i_addr_q[1:0];
   assign i_rng  = (i_addr_q >> (ADDR_BITS + 3)) == 64'd0;
   assign i_err  = i_mis || !(i_rng || i_mmio);
   assign i_word = mem[i_addr_q[ADDR_BITS+2:3]];

   always_ff @(posedge phi2) begin
      if (rst) begin
         i_state_q <= IDLE;
         i_cnt_q   <= '0;
         i_addr_q  <= '0;
         i_data_q  <= '0;
      end else begin
         i_state_q <= i_state_d;
         i_cnt_q   <= i_cnt_d;
         if (i_state_q == IDLE && input_instruction_request)
            i_addr_q <= instruction_address;
         if (i_state_q == WAIT && i_state_d == DONE)
            i_data_q <= (!i_mis && i_rng) ?
                        (i_addr_q[2] ? i_word[63:32] : i_word[31:0]) : '0;
      end
   end

   assign input_instruction       = i_data_q;
   assign input_instruction_valid = (i_state_q == DONE);

   // ---------------- data port ----------------
   // Write wins when both requests arrive together; the read stays
   // pending on its request line and is taken after the write's DONE.
   assign d_accept = (d_state_q == IDLE) &&
                     (output_data_request || input_data_request);
   // A console write cannot finish while the FIFO is full.
   assign d_hold   = d_we_q && d_con && con_full;

   always_comb begin
      d_state_d = d_state_q;
      d_cnt_d   = d_cnt_q;
      unique case (d_state_q)
         IDLE: if (output_data_request) begin
            d_state_d = WAIT;
            d_cnt_d   = 4'(WRITE_LATENCY - 1);
         end else if (input_data_request) begin
            d_state_d = WAIT;
            d_cnt_d   = 4'(READ_LATENCY - 1);
         end
         WAIT: if (d_cnt_q != 4'd0) d_cnt_d = d_cnt_q - 4'd1;
               else if (!d_hold) d_state_d = DONE;
         DONE: d_state_d = IDLE;
         default: d_state_d = IDLE;
      endcase
   end

   always_comb begin
      d_mis = 1'b0;
      unique case (d_size_q)
         2'd0: d_mis = 1'b0;
         2'd1: d_mis = d_addr_q[0];
         2'd2: d_mis = |d_addr_q[1:0];
         2'd3: d_mis = |d_addr_q[2:0];
         default: d_mis = 1'b0;
      endcase
   end

   assign d_rng    = (d_addr_q >> (ADDR_BITS + 3)) == 64'd0;
   assign d_ram_ok = !d_mis && d_rng;
   assign d_err    = d_mis || !(d_rng || d_mmio);
   assign d_commit = (d_state_q == DONE) && d_we_q && !rst;
   assign d_word   = mem[d_addr_q[ADDR_BITS+2:3]];
   assign d_sh     = d_word >> {d_addr_q[2:0], 3'b000};
   assign d_wsh    = d_wdata_q << {d_addr_q[2:0], 3'b000};

   always_comb begin
      d_fmt  = d_word;
      d_mask = 8'hFF;
      unique case (d_size_q)
         2'd0: begin
            d_fmt  = d_uns_q ? {56'd0, d_sh[7:0]} :
                     {{56{d_sh[7]}}, d_sh[7:0]};
            d_mask = 8'h01 << d_addr_q[2:0];
         end
         2'd1: begin
            d_fmt  = d_uns_q ? {48'd0, d_sh[15:0]} :
                     {{48{d_sh[15]}}, d_sh[15:0]};
            d_mask = 8'h03 << {d_addr_q[2:1], 1'b0};
         end
         2'd2: begin
            d_fmt  = d_uns_q ? {32'd0, d_sh[31:0]} :
                     {{32{d_sh[31]}}, d_sh[31:0]};
            d_mask = 8'h0F << {d_addr_q[2], 2'b00};
         end
         default: begin
            d_fmt  = d_word;
            d_mask = 8'hFF;
         end
      endcase
   end

   always_ff @(posedge phi2) begin
      if (rst) begin
         d_state_q <= IDLE;
         d_cnt_q   <= '0;
         d_addr_q  <= '0;
         d_wdata_q <= '0;
         d_size_q  <= '0;
         d_uns_q   <= 1'b0;
         d_we_q    <= 1'b0;
         d_rdata_q <= '0;
      end else begin
         d_state_q <= d_state_d;
         d_cnt_q   <= d_cnt_d;
         if (d_accept) begin
            d_addr_q  <= data_address;
            d_size_q  <= data_size;
            d_uns_q   <= input_data_unsigned;
            d_wdata_q <= output_data;
            d_we_q    <= output_data_request;
         end
         if (d_state_q == WAIT && d_state_d == DONE && !d_we_q)
            d_rdata_q <= d_ram_ok ? d_fmt : '0;
      end
   end

   always_ff @(posedge phi2) begin
      if (d_commit && d_ram_ok)
         for (int b = 0; b < 8; b++)
            if (d_mask[b]) mem[d_addr_q[ADDR_BITS+2:3]][b*8 +: 8] <= d_wsh[b*8 +: 8];
   end

   always_ff @(posedge phi2) begin
      if (rst) bus_error_q <= 1'b0;
      else if ((i_state_q == DONE && i_err) || (d_state_q == DONE && d_err))
         bus_error_q <= 1'b1;
   end

   assign input_data           = d_rdata_q;
   assign input_data_valid     = (d_state_q == DONE) && !d_we_q;
   assign output_data_complete = (d_state_q == DONE) && d_we_q;
   assign bus_error            = bus_error_q;

`ifdef BUS_MEMORY_MMIO_EN
   localparam int PW = $clog2(CONSOLE_DEPTH);

   logic [7:0]    con_mem_q [CONSOLE_DEPTH];
   logic [PW-1:0] rd_q, wr_q;
   logic [PW:0]   cnt_q;
   logic          con_push, con_pop, halted_q, int_valid_q;
   logic [63:0]   int_data_q;

   assign i_mmio   = i_addr_q inside {A_INT, A_HALT, A_CON};
   assign d_mmio   = d_addr_q inside {A_INT, A_HALT, A_CON};
   assign d_con    = !d_mis && d_addr_q == A_CON;
   assign d_halt   = !d_mis && d_addr_q == A_HALT;
   assign d_int    = !d_mis && d_addr_q == A_INT;
   assign con_full = cnt_q == (PW+1)'(CONSOLE_DEPTH);
   assign con_push = d_commit && d_con;
   assign con_pop  = console_valid && console_ready;

   always_ff @(posedge phi2) begin
      if (con_push) con_mem_q[wr_q] <= d_wdata_q[7:0];
   end

   always_ff @(posedge phi2) begin
      if (rst) begin
         rd_q        <= '0;
         wr_q        <= '0;
         cnt_q       <= '0;
         halted_q    <= 1'b0;
         int_valid_q <= 1'b0;
         int_data_q  <= '0;
      end else begin
         if (con_push) wr_q <= wr_q + 1'b1;
         if (con_pop)  rd_q <= rd_q + 1'b1;
         cnt_q       <= cnt_q + (PW+1)'(con_push) - (PW+1)'(con_pop);
         int_valid_q <= d_commit && d_int;
         if (d_commit && d_int)  int_data_q <= d_wdata_q;
         if (d_commit && d_halt) halted_q <= 1'b1;
      end
   end

   assign console_data  = con_mem_q[rd_q];
   assign console_valid = cnt_q != '0;
   assign int_data      = int_data_q;
   assign int_valid     = int_valid_q;
   assign halted        = halted_q;
`else
   logic unused_mmio;
   assign unused_mmio   = console_ready;
   assign i_mmio        = 1'b0;
   assign d_mmio        = 1'b0;
   assign d_con         = 1'b0;
   assign d_halt        = 1'b0;
   assign d_int         = 1'b0;
   assign con_full      = 1'b0;
   assign console_data  = '0;
   assign console_valid = 1'b0;
   assign int_data      = '0;
   assign int_valid     = 1'b0;
   assign halted        = 1'b0;
`endif

endmodule
